control_sequencer: RTL and testbench

Hardwired control unit for the MiniSRC datapath. A one-hot T-step state machine sequences instruction fetch, decode and execute, and handshakes with memory through `mem_ready`. It drives a flat control word into `datapath` and implements the board-level run/stop/halt behaviour; `run` is owned by this block.

---
 rtl/control_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired MiniSRC control unit: a one-hot T-step FSM that walks fetch/decode/execute,
// waits on memory through mem_ready, and owns the board-level run/stop/halt state.
module control_sequencer #(
  parameter int CTL_W = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stop,
  input  logic [4:0]       opcode,
  input  logic             con_ff,
  input  logic             mem_ready,
  output logic [CTL_W-1:0] ctl,
  output logic [4:0]       alu_op,
  output logic [2:0]       step,
  output logic             run
);

  localparam int B_PC_OUT = 0,  B_MAR_IN = 1,  B_INC_PC = 2,  B_Z_IN = 3;
  localparam int B_ZLO_OUT = 4, B_ZHI_OUT = 5, B_PC_IN = 6,   B_MEM_READ = 7;
  localparam int B_MEM_WRITE = 8, B_MDR_IN = 9, B_MDR_OUT = 10, B_IR_IN = 11;
  localparam int B_GRA = 12, B_GRB = 13, B_GRC = 14, B_R_IN = 15, B_R_OUT = 16;
  localparam int B_BA_OUT = 17, B_C_OUT = 18, B_Y_IN = 19, B_HI_IN = 20, B_LO_IN = 21;
  localparam int B_HI_OUT = 22, B_LO_OUT = 23, B_CON_IN = 24, B_INPORT_OUT = 25;
  localparam int B_OUTPORT_IN = 26, B_ILLEGAL = 27;

  localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_ADD = 5'd3;
  localparam logic [4:0] OP_SUB = 5'd4, OP_SHR = 5'd5, OP_SHL = 5'd6, OP_ROR = 5'd7;
  localparam logic [4:0] OP_ROL = 5'd8, OP_AND = 5'd9, OP_OR = 5'd10, OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12, OP_ORI = 5'd13, OP_MUL = 5'd14, OP_DIV = 5'd15;
  localparam logic [4:0] OP_NEG = 5'd16, OP_NOT = 5'd17, OP_BRX = 5'd18, OP_JR = 5'd19;
  localparam logic [4:0] OP_JAL = 5'd20, OP_IN = 5'd21, OP_OUT = 5'd22, OP_MFHI = 5'd23;
  localparam logic [4:0] OP_MFLO = 5'd24, OP_NOP = 5'd25, OP_HALT = 5'd26;

  typedef enum logic [10:0] {
    S_RESET   = 11'b000_0000_0001,
    S_T0      = 11'b000_0000_0010,
    S_T1      = 11'b000_0000_0100,
    S_T2      = 11'b000_0000_1000,
    S_T3      = 11'b000_0001_0000,
    S_T4      = 11'b000_0010_0000,
    S_T5      = 11'b000_0100_0000,
    S_T6      = 11'b000_1000_0000,
    S_T7      = 11'b001_0000_0000,
    S_STOPPED = 11'b010_0000_0000,
    S_HALTED  = 11'b100_0000_0000
  } state_e;

  state_e state_q, state_d;

  logic cls_rr, cls_imm, cls_muldiv, cls_negnot, cls_ld, cls_st, cls_brx;
  logic cls_jr, cls_jal, cls_in, cls_out, cls_mfhi, cls_mflo, cls_nop, cls_halt, cls_illegal;
  logic last_step, mem_hold;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    cls_rr = 1'b0; cls_imm = 1'b0; cls_muldiv = 1'b0; cls_negnot = 1'b0;
    cls_ld = 1'b0; cls_st = 1'b0; cls_brx = 1'b0; cls_jr = 1'b0; cls_jal = 1'b0;
    cls_in = 1'b0; cls_out = 1'b0; cls_mfhi = 1'b0; cls_mflo = 1'b0;
    cls_nop = 1'b0; cls_halt = 1'b0; cls_illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR: cls_rr = 1'b1;
      OP_LDI, OP_ADDI, OP_ANDI, OP_ORI: cls_imm = 1'b1;
      OP_MUL, OP_DIV:  cls_muldiv = 1'b1;
      OP_NEG, OP_NOT:  cls_negnot = 1'b1;
      OP_LD:   cls_ld = 1'b1;
      OP_ST:   cls_st = 1'b1;
      OP_BRX:  cls_brx = 1'b1;
      OP_JR:   cls_jr = 1'b1;
      OP_JAL:  cls_jal = 1'b1;
      OP_IN:   cls_in = 1'b1;
      OP_OUT:  cls_out = 1'b1;
      OP_MFHI: cls_mfhi = 1'b1;
      OP_MFLO: cls_mflo = 1'b1;
      OP_NOP:  cls_nop = 1'b1;
      OP_HALT: cls_halt = 1'b1;
      default: cls_illegal = 1'b1;
    endcase
  end

  // Moore outputs: only state_q, opcode and con_ff feed the strobes.
  always_comb begin
    ctl    = '0;
    alu_op = 5'd0;
    step   = 3'd0;
    run    = 1'b0;
    unique case (state_q)
      S_T0: begin
        step = 3'd0;
        ctl[B_PC_OUT] = 1'b1; ctl[B_MAR_IN] = 1'b1; ctl[B_INC_PC] = 1'b1; ctl[B_Z_IN] = 1'b1;
      end
      S_T1: begin
        step = 3'd1;
        ctl[B_ZLO_OUT] = 1'b1; ctl[B_PC_IN] = 1'b1; ctl[B_MEM_READ] = 1'b1; ctl[B_MDR_IN] = 1'b1;
      end
      S_T2: begin
        step = 3'd2;
        ctl[B_MDR_OUT] = 1'b1; ctl[B_IR_IN] = 1'b1;
      end
      S_T3: begin
        step = 3'd3;
        if (cls_rr)                   begin ctl[B_GRB] = 1'b1; ctl[B_R_OUT] = 1'b1; ctl[B_Y_IN] = 1'b1; end
        if (cls_imm || cls_ld || cls_st) begin ctl[B_GRB] = 1'b1; ctl[B_BA_OUT] = 1'b1; ctl[B_Y_IN] = 1'b1; end
        if (cls_muldiv)               begin ctl[B_GRA] = 1'b1; ctl[B_R_OUT] = 1'b1; ctl[B_Y_IN] = 1'b1; end
        if (cls_negnot)               begin ctl[B_GRB] = 1'b1; ctl[B_R_OUT] = 1'b1; ctl[B_Z_IN] = 1'b1; end
        if (cls_brx)                  begin ctl[B_GRA] = 1'b1; ctl[B_R_OUT] = 1'b1; ctl[B_CON_IN] = 1'b1; end
        if (cls_jr)                   begin ctl[B_GRA] = 1'b1; ctl[B_R_OUT] = 1'b1; ctl[B_PC_IN] = 1'b1; end
        if (cls_jal)                  begin ctl[B_PC_OUT] = 1'b1; ctl[B_GRA] = 1'b1; ctl[B_R_IN] = 1'b1; end
        if (cls_in)                   begin ctl[B_INPORT_OUT] = 1'b1; ctl[B_GRA] = 1'b1; ctl[B_R_IN] = 1'b1; end
        if (cls_out)                  begin ctl[B_GRA] = 1'b1; ctl[B_R_OUT] = 1'b1; ctl[B_OUTPORT_IN] = 1'b1; end
        if (cls_mfhi)                 begin ctl[B_HI_OUT] = 1'b1; ctl[B_GRA] = 1'b1; ctl[B_R_IN] = 1'b1; end
        if (cls_mflo)                 begin ctl[B_LO_OUT] = 1'b1; ctl[B_GRA] = 1'b1; ctl[B_R_IN] = 1'b1; end
        if (cls_illegal)              ctl[B_ILLEGAL] = 1'b1;
      end
      S_T4: begin
        step = 3'd4;
        if (cls_rr)                   begin ctl[B_GRC] = 1'b1; ctl[B_R_OUT] = 1'b1; ctl[B_Z_IN] = 1'b1; end
        if (cls_imm || cls_ld || cls_st) begin ctl[B_C_OUT] = 1'b1; ctl[B_Z_IN] = 1'b1; end
        if (cls_muldiv)               begin ctl[B_GRB] = 1'b1; ctl[B_R_OUT] = 1'b1; ctl[B_Z_IN] = 1'b1; end
        if (cls_negnot)               begin ctl[B_ZLO_OUT] = 1'b1; ctl[B_GRA] = 1'b1; ctl[B_R_IN] = 1'b1; end
        if (cls_brx)                  begin ctl[B_PC_OUT] = 1'b1; ctl[B_Y_IN] = 1'b1; end
        if (cls_jal)                  begin ctl[B_GRB] = 1'b1; ctl[B_R_OUT] = 1'b1; ctl[B_PC_IN] = 1'b1; end
      end
      S_T5: begin
        step = 3'd5;
        if (cls_rr || cls_imm)        begin ctl[B_ZLO_OUT] = 1'b1; ctl[B_GRA] = 1'b1; ctl[B_R_IN] = 1'b1; end
        if (cls_ld || cls_st)         begin ctl[B_ZLO_OUT] = 1'b1; ctl[B_MAR_IN] = 1'b1; end
        if (cls_muldiv)               begin ctl[B_ZLO_OUT] = 1'b1; ctl[B_LO_IN] = 1'b1; end
        if (cls_brx)                  begin ctl[B_C_OUT] = 1'b1; ctl[B_Z_IN] = 1'b1; end
      end
      S_T6: begin
        step = 3'd6;
        if (cls_ld)                   begin ctl[B_MEM_READ] = 1'b1; ctl[B_MDR_IN] = 1'b1; end
        if (cls_st)                   begin ctl[B_GRA] = 1'b1; ctl[B_R_OUT] = 1'b1; ctl[B_MDR_IN] = 1'b1; end
        if (cls_muldiv)               begin ctl[B_ZHI_OUT] = 1'b1; ctl[B_HI_IN] = 1'b1; end
        if (cls_brx)                  begin ctl[B_ZLO_OUT] = 1'b1; ctl[B_PC_IN] = con_ff; end
      end
      S_T7: begin
        step = 3'd7;
        if (cls_ld)                   begin ctl[B_MDR_OUT] = 1'b1; ctl[B_GRA] = 1'b1; ctl[B_R_IN] = 1'b1; end
        if (cls_st)                   ctl[B_MEM_WRITE] = 1'b1;
      end
      default: ;
    endcase
    if (state_q inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7}) begin
      run    = 1'b1;
      alu_op = (state_q == S_T0 || cls_ld || cls_st || opcode == OP_LDI || cls_brx) ? OP_ADD : opcode;
    end
  end

  // Final step of each instruction class; the memory wait is resolved separately.
  always_comb begin
    last_step = 1'b0;
    mem_hold  = (ctl[B_MEM_READ] || ctl[B_MEM_WRITE]) && !mem_ready;
    state_d   = state_q;
    unique case (state_q)
      S_T3: last_step = cls_jr || cls_in || cls_out || cls_mfhi || cls_mflo ||
                        cls_nop || cls_halt || cls_illegal;
      S_T4: last_step = cls_negnot || cls_jal;
      S_T5: last_step = cls_rr || cls_imm;
      S_T6: last_step = cls_muldiv || cls_brx;
      S_T7: last_step = 1'b1;
      default: last_step = 1'b0;
    endcase
    unique case (state_q)
      S_RESET, S_STOPPED: state_d = stop ? S_STOPPED : S_T0;
      S_HALTED:           state_d = S_HALTED;
      default: begin
        if (mem_hold)       state_d = state_q;
        else if (last_step) state_d = cls_halt ? S_HALTED : (stop ? S_STOPPED : S_T0);
        else begin
          unique case (state_q)
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = S_T6;
            S_T6:    state_d = S_T7;
            default: state_d = S_T0;
          endcase
        end
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus random traffic,
// all compared against a table-driven model of each instruction's step sequence.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stop = 1'b0;
  logic [4:0]  opcode = 5'd3;
  logic        con_ff = 1'b0;
  logic        mem_ready = 1'b1;
  logic [27:0] ctl;
  logic [4:0]  alu_op;
  logic [2:0]  step;
  logic        run;

  int checks = 0;
  int failures = 0;

  localparam int MR = 0, MRUN = 1, MSTOP = 2, MHALT = 3;
  int m_mode = MR;
  int m_step = 0;

  control_sequencer #(.CTL_W(28)) dut (
    .clk(clk), .reset(reset), .stop(stop), .opcode(opcode), .con_ff(con_ff),
    .mem_ready(mem_ready), .ctl(ctl), .alu_op(alu_op), .step(step), .run(run)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] sb(input int a = -1, input int b = -1,
                                     input int c = -1, input int d = -1);
    logic [27:0] m = '0;
    if (a >= 0) m[a] = 1'b1;
    if (b >= 0) m[b] = 1'b1;
    if (c >= 0) m[c] = 1'b1;
    if (d >= 0) m[d] = 1'b1;
    return m;
  endfunction

  // Strobe table for one instruction, indexed by T-step.
  function automatic logic [27:0] seq_mask(input logic [4:0] op, input int t, input logic con);
    logic [27:0] s [8];
    for (int i = 0; i < 8; i++) s[i] = '0;
    s[0] = sb(0, 1, 2, 3);
    s[1] = sb(4, 6, 7, 9);
    s[2] = sb(10, 11);
    case (op) inside
      [5'd3:5'd10]: begin s[3] = sb(13, 16, 19); s[4] = sb(14, 16, 3); s[5] = sb(4, 12, 15); end
      5'd1, [5'd11:5'd13]: begin s[3] = sb(13, 17, 19); s[4] = sb(18, 3); s[5] = sb(4, 12, 15); end
      5'd14, 5'd15: begin s[3] = sb(12, 16, 19); s[4] = sb(13, 16, 3); s[5] = sb(4, 21); s[6] = sb(5, 20); end
      5'd16, 5'd17: begin s[3] = sb(13, 16, 3); s[4] = sb(4, 12, 15); end
      5'd0: begin s[3] = sb(13, 17, 19); s[4] = sb(18, 3); s[5] = sb(4, 1); s[6] = sb(7, 9); s[7] = sb(10, 12, 15); end
      5'd2: begin s[3] = sb(13, 17, 19); s[4] = sb(18, 3); s[5] = sb(4, 1); s[6] = sb(12, 16, 9); s[7] = sb(8); end
      5'd18: begin s[3] = sb(12, 16, 24); s[4] = sb(0, 19); s[5] = sb(18, 3); s[6] = con ? sb(4, 6) : sb(4); end
      5'd19: s[3] = sb(12, 16, 6);
      5'd20: begin s[3] = sb(0, 12, 15); s[4] = sb(13, 16, 6); end
      5'd21: s[3] = sb(25, 12, 15);
      5'd22: s[3] = sb(12, 16, 26);
      5'd23: s[3] = sb(22, 12, 15);
      5'd24: s[3] = sb(23, 12, 15);
      5'd25, 5'd26: ;
      default: s[3] = sb(27);
    endcase
    return s[t];
  endfunction

  function automatic int last_step(input logic [4:0] op);
    case (op) inside
      5'd0, 5'd2: return 7;
      5'd14, 5'd15, 5'd18: return 6;
      5'd1, [5'd3:5'd13]: return 5;
      5'd16, 5'd17, 5'd20: return 4;
      default: return 3;
    endcase
  endfunction

  task automatic model_next();
    logic [27:0] m;
    if (reset) begin m_mode = MR; m_step = 0; end
    else case (m_mode)
      MR:    begin m_mode = stop ? MSTOP : MRUN; m_step = 0; end
      MSTOP: if (!stop) begin m_mode = MRUN; m_step = 0; end
      MHALT: ;
      default: begin
        m = seq_mask(opcode, m_step, con_ff);
        if ((m[7] || m[8]) && !mem_ready) ;
        else if (m_step == last_step(opcode)) begin
          m_step = 0;
          if (opcode == 5'd26) m_mode = MHALT;
          else if (stop)       m_mode = MSTOP;
        end else m_step++;
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [27:0] e_ctl;
    logic [4:0]  e_alu;
    e_ctl = (m_mode == MRUN) ? seq_mask(opcode, m_step, con_ff) : '0;
    chk("ctl", ctl, e_ctl);
    chk("step", 28'(step), (m_mode == MRUN) ? 28'(m_step) : 28'd0);
    chk("run", 28'(run), (m_mode == MRUN) ? 28'd1 : 28'd0);
    if (m_mode == MR) chk("alu_op_reset", 28'(alu_op), 28'd0);
    if (m_mode == MRUN) begin
      e_alu = (m_step == 0 || opcode inside {5'd0, 5'd1, 5'd2, 5'd18}) ? 5'd3 : opcode;
      chk("alu_op", 28'(alu_op), 28'(e_alu));
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic stp, input logic [4:0] op,
                               input logic con, input logic mr);
    reset = rst; stop = stp; opcode = op; con_ff = con; mem_ready = mr;
    model_next();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  // Runs one instruction from T0 with optional fetch / execute memory waits.
  task automatic run_instr(input logic [4:0] op, input logic con, input int w1, input int wx,
                           output int cnt, output int ill);
    logic mr;
    cnt = 0; ill = 0;
    do begin
      mr = 1'b1;
      if (m_mode == MRUN && m_step == 1 && w1 > 0) begin mr = 1'b0; w1--; end
      else if (m_mode == MRUN && m_step >= 6 && (seq_mask(op, m_step, con) & sb(7, 8)) != 0 && wx > 0) begin
        mr = 1'b0; wx--;
      end
      applyStimulus(1'b0, 1'b0, op, con, mr);
      cnt++;
      if (ctl[27]) ill++;
      if (m_mode == MRUN && m_step == 2) chk("ir_in_t2", 28'(ctl[11]), 28'd1);
      if (op == 5'd18 && m_mode == MRUN && m_step == 6) begin
        chk("brx_pc_in", 28'(ctl[6]), 28'(con));
        chk("brx_zlo_out", 28'(ctl[4]), 28'd1);
      end
      if (op == 5'd3 && m_mode == MRUN && m_step == 5)
        chk("add_t5_bits", ctl & sb(4, 12, 15), sb(4, 12, 15));
    end while (!(m_mode == MRUN && m_step == 0) && m_mode != MHALT && cnt < 64);
  endtask

  initial begin
    int cnt, ill;
    logic r, s;
    logic [4:0] op;

    $display("[TB] start");
    applyStimulus(1'b1, 1'b0, 5'd3, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 5'd3, 1'b0, 1'b1);
    chk("reset_ctl", ctl, 28'd0);
    applyStimulus(1'b0, 1'b0, 5'd3, 1'b0, 1'b1);
    chk("reset_exit_run", 28'(run), 28'd1);

    run_instr(5'd3, 1'b0, 0, 0, cnt, ill);  chk("add_cycles", 28'(cnt), 28'd6);
    run_instr(5'd0, 1'b0, 2, 3, cnt, ill);  chk("ld_cycles", 28'(cnt), 28'd13);
    run_instr(5'd18, 1'b1, 0, 0, cnt, ill); chk("brx1_cycles", 28'(cnt), 28'd7);
    run_instr(5'd18, 1'b0, 0, 0, cnt, ill); chk("brx0_cycles", 28'(cnt), 28'd7);
    run_instr(5'd14, 1'b0, 0, 0, cnt, ill); chk("mul_cycles", 28'(cnt), 28'd7);
    run_instr(5'd2, 1'b0, 1, 2, cnt, ill);  chk("st_cycles", 28'(cnt), 28'd11);
    run_instr(5'd19, 1'b0, 0, 0, cnt, ill); chk("jr_cycles", 28'(cnt), 28'd4);
    run_instr(5'd25, 1'b0, 0, 0, cnt, ill); chk("nop_cycles", 28'(cnt), 28'd4);

    // sub with stop raised in T4 and held five cycles
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 5'd4, 1'b0, 1'b1);
    chk("sub_at_t4", 28'(step), 28'd4);
    applyStimulus(1'b0, 1'b1, 5'd4, 1'b0, 1'b1);
    chk("sub_t5_completes", 28'(step), 28'd5);
    applyStimulus(1'b0, 1'b1, 5'd4, 1'b0, 1'b1);
    chk("stopped_run", 28'(run), 28'd0);
    chk("stopped_ctl", ctl, 28'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 5'd4, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd4, 1'b0, 1'b1);
    chk("resume_t0", {27'd0, run} | (28'(step) << 1), 28'd1);

    // halt ignores stop; only reset leaves
    run_instr(5'd26, 1'b0, 0, 0, cnt, ill); chk("halt_cycles", 28'(cnt), 28'd4);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'(i % 2), 5'd26, 1'b0, 1'b1);
      chk("halted_run", 28'(run), 28'd0);
    end
    applyStimulus(1'b1, 1'b0, 5'd2, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd2, 1'b0, 1'b1);
    chk("halt_reset_t0_run", 28'(run), 28'd1);

    // reset during the st write wait
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 5'd2, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd2, 1'b0, 1'b0);
    chk("st_wait_mem_write", 28'(ctl[8]), 28'd1);
    applyStimulus(1'b1, 1'b0, 5'd2, 1'b0, 1'b0);
    chk("rst_in_wait_ctl", ctl, 28'd0);
    chk("rst_in_wait_step", 28'(step), 28'd0);
    applyStimulus(1'b0, 1'b0, 5'd31, 1'b0, 1'b1);
    run_instr(5'd31, 1'b0, 0, 0, cnt, ill);
    chk("illegal_cycles", 28'(ill), 28'd1);
    chk("illegal_len", 28'(cnt), 28'd4);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 99) == 0) || (m_mode == MHALT && $urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 9) == 0) ? ~stop : stop;
      op = opcode;
      if (m_mode == MRUN && m_step == 2) op = 5'($urandom_range(0, 31));
      applyStimulus(r, s, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
